// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock, MSB first
module seq_divider #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         div_zero
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  p;
    logic [W-1:0]  d;
    logic [W-1:0]  dv;
    logic [CW-1:0] cnt;
    logic [W:0]    shifted;
    logic [W-1:0]  diff;
    logic          ge;
    logic [W-1:0]  p_next;
    logic [W-1:0]  d_next;

    // one restoring step: shift the next dividend bit into the W+1-bit partial remainder and try the subtract
    always_comb begin
        shifted = {p, d[W-1]};
        ge      = shifted >= {1'b0, dv};
        diff    = shifted[W-1:0] - dv;
        p_next  = ge ? diff : shifted[W-1:0];
        d_next  = {d[W-2:0], ge};
    end

    // control FSM with registered outputs; DONE accepts a new start exactly like IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            p        <= '0;
            d        <= '0;
            dv       <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    p   <= p_next;
                    d   <= d_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        q     <= d_next;
                        r     <= p_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    if (start && y == '0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        q        <= '1;
                        r        <= x;
                        div_zero <= 1'b1;
                    end else if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        p        <= '0;
                        d        <= x;
                        dv       <= y;
                        cnt      <= CW'(W);
                        div_zero <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
